// File: rtl/fp_sub_seq.sv
// rtl/fp_sub_seq.sv - multi-cycle binary32 subtractor (A - B); FP_SUB_RNE_EN selects round-to-nearest-even, else truncation
module fp_sub_seq #(
  parameter int XLEN      = 32,
  parameter int ALIGN_CAP = 26
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception,
  output logic            busy
);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE} state_t;

  state_t             state;
  logic [31:0]        a_r, b_r;
  logic               sx, eff_sub;
  logic signed [9:0]  ex;
  logic [27:0]        mx;        // {carry, hidden, 23-bit fraction, G, R, S}
  logic [26:0]        my;        // {hidden, 23-bit fraction, G, R, S}
  logic [4:0]         align_cnt;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // Operand classification and magnitude ordering for the UNPACK step
  logic        a_s, b_ns, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge;
  logic [7:0]  x_e, y_e, diff;
  logic [22:0] x_m, y_m;
  always_comb begin
    a_s    = a_r[31];
    b_ns   = ~b_r[31];
    a_zero = (a_r[30:23] == 8'h00);
    b_zero = (b_r[30:23] == 8'h00);
    a_inf  = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'h0);
    b_inf  = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'h0);
    a_nan  = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'h0);
    b_nan  = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'h0);
    a_ge   = (a_r[30:0] >= b_r[30:0]);
    x_e    = a_ge ? a_r[30:23] : b_r[30:23];
    y_e    = a_ge ? b_r[30:23] : a_r[30:23];
    x_m    = a_ge ? a_r[22:0]  : b_r[22:0];
    y_m    = a_ge ? b_r[22:0]  : a_r[22:0];
    diff   = x_e - y_e;
  end

  // Mantissa add/subtract; X is never smaller than Y so subtraction cannot go negative
  logic [27:0] sum_c;
  always_comb begin
    sum_c = eff_sub ? (mx - {1'b0, my}) : (mx + {1'b0, my});
  end

  // Rounding and final exponent for PACK
  logic              round_up;
  logic [24:0]       rounded;
  logic signed [9:0] exp_f;
  logic [22:0]       frac_f;
  always_comb begin
`ifdef FP_SUB_RNE_EN
    round_up = mx[2] & (mx[1] | mx[0] | mx[3]);
`else
    round_up = 1'b0;
`endif
    rounded = {1'b0, 1'b1, mx[25:3]} + {24'h0, round_up};
    exp_f   = ex + $signed({9'h0, rounded[24]});
    frac_f  = rounded[24] ? rounded[23:1] : rounded[22:0];
  end

  // Control FSM with registered result and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sx        <= 1'b0;
      eff_sub   <= 1'b0;
      ex        <= '0;
      mx        <= '0;
      my        <= '0;
      align_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r       <= A;
            b_r       <= B;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
            state     <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (a_nan || b_nan || (a_inf && b_inf && (a_s == b_r[31]))) begin
            result    <= 32'h7FC0_0000;
            exception <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (a_inf || b_inf || a_zero || b_zero) begin
            if (a_inf)                result <= a_r;
            else if (b_inf)           result <= {b_ns, b_r[30:0]};
            else if (a_zero && b_zero) result <= {a_s & b_ns, 31'h0};
            else if (a_zero)          result <= {b_ns, b_r[30:0]};
            else                      result <= a_r;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            sx        <= a_ge ? a_s : b_ns;
            eff_sub   <= (a_s != b_ns);
            ex        <= $signed({2'b00, x_e});
            mx        <= {2'b01, x_m, 3'b000};
            my        <= {1'b1, y_m, 3'b000};
            align_cnt <= (diff >= 8'(ALIGN_CAP)) ? 5'(ALIGN_CAP) : diff[4:0];
            state     <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (align_cnt != 5'd0) begin
            my        <= {1'b0, my[26:2], my[1] | my[0]};
            align_cnt <= align_cnt - 5'd1;
          end
          if (align_cnt <= 5'd1) state <= S_ADD;
        end
        S_ADD: begin
          if (sum_c == 28'h0) begin
            result    <= 32'h0000_0000;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            mx    <= sum_c;
            state <= (sum_c[27] || !sum_c[26]) ? S_NORM : S_PACK;
          end
        end
        S_NORM: begin
          if (mx[27]) begin
            mx    <= {1'b0, mx[27:2], mx[1] | mx[0]};
            ex    <= ex + 10'sd1;
            state <= S_PACK;
          end else begin
            mx <= {mx[26:0], 1'b0};
            ex <= ex - 10'sd1;
            if (mx[25] || ex <= 10'sd1) state <= S_PACK;
          end
        end
        S_PACK: begin
          if (exp_f >= 10'sd255) begin
            result   <= {sx, 8'hFF, 23'h0};
            overflow <= 1'b1;
          end else if (exp_f <= 10'sd0) begin
            result    <= {sx, 31'h0};
            underflow <= 1'b1;
          end else begin
            result <= {sx, exp_f[7:0], frac_f};
          end
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// tb/tb_fp_sub_seq.sv - directed self-checking bench for fp_sub_seq
module tb_fp_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, result;
  logic        overflow, underflow, exception, busy;

  int checks = 0;
  int errors = 0;

  fp_sub_seq #(.XLEN(32), .ALIGN_CAP(26)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow),
    .exception(exception), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  {31'h0, in_ready},  32'd1);
    check({tag, "_out_valid"}, {31'h0, out_valid}, 32'd0);
    check({tag, "_result"},    result,             32'h0);
    check({tag, "_flags"},     {29'h0, overflow, underflow, exception}, 32'd0);
    check({tag, "_busy"},      {31'h0, busy},      32'd0);
  endtask

  logic [31:0] r_res;
  logic [2:0]  r_flags;
  int          r_lat;

  // Issue one operation, wait (bounded) for the result, then pop it
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit pop);
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    r_lat = 1;
    while (!out_valid && r_lat < 200) begin
      @(posedge clk); #1;
      r_lat++;
    end
    if (!out_valid) check("timeout", 32'd0, 32'd1);
    r_res   = result;
    r_flags = {overflow, underflow, exception};
    if (pop) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("pop_clears_valid", {31'h0, out_valid}, 32'd0);
    end
  endtask

  task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [2:0] exp_flags);
    run_op(a, b, 1'b1);
    check({tag, "_res"},   r_res, exp_res);
    check({tag, "_flags"}, {29'h0, r_flags}, {29'h0, exp_flags});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk); rst = 1'b0;

    // flags order: {overflow, underflow, exception}
    op_check("5m3", 32'h40A0_0000, 32'h4040_0000, 32'h4000_0000, 3'b000);
    run_op(32'h40A0_0000, 32'h4040_0000, 1'b1);
    check("5m3_latency", r_lat, 32'd6);
    op_check("1m1",  32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3'b000);
    op_check("1mn1", 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 3'b000);
    op_check("ovf",  32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 3'b100);
    op_check("infminf", 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 3'b001);
    run_op(32'h7F80_0000, 32'h7F80_0000, 1'b1);
    check("special_latency", r_lat, 32'd2);
`ifdef FP_SUB_RNE_EN
    op_check("round", 32'h3F80_0000, 32'hB3C0_0000, 32'h3F80_0001, 3'b000);
`else
    op_check("round", 32'h3F80_0000, 32'hB3C0_0000, 32'h3F80_0000, 3'b000);
`endif
    op_check("1m2",   32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 3'b000);
    op_check("0m1",   32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 3'b000);
    op_check("nan",   32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 3'b001);
    op_check("infm1", 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 3'b000);
    op_check("uflow", 32'h0080_0000, 32'h00C0_0000, 32'h8000_0000, 3'b010);
    op_check("flags_cleared", 32'h40A0_0000, 32'h4040_0000, 32'h4000_0000, 3'b000);

    // DONE holds result stable while stalled, ignoring new in_valid
    run_op(32'h40A0_0000, 32'h4040_0000, 1'b0);
    @(negedge clk);
    A = 32'h3F80_0000; B = 32'hBF80_0000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid", {31'h0, out_valid}, 32'd1);
      check("stall_result", result, 32'h4000_0000);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_pop", {31'h0, out_valid}, 32'd0);

    // Reset during ALIGN (exponent gap 20)
    @(negedge clk);
    A = 32'h4B00_0000; B = 32'h4100_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", {31'h0, busy}, 32'd1);
    check("mid_in_ready", {31'h0, in_ready}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("abort");
    @(negedge clk); rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("no_partial_result", seen, 32'd0);
    end
    op_check("after_abort", 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
